// File: rtl/alp_mdsq.sv
// Booth radix-2 multiply / non-restoring divide step sequencer driving the dc608 ALP slice chain.
// Optional abort input is enabled by defining ALP_MDSQ_ABORT_EN.
module alp_mdsq #(
    parameter int unsigned WIDTH    = 32,
    parameter logic [9:0]  OPC_NOP  = 10'h000,
    parameter logic [9:0]  OPC_PASS = 10'h001,
    parameter logic [9:0]  OPC_ADD  = 10'h002,
    parameter logic [9:0]  OPC_SUB  = 10'h003
) (
    input  logic       qdck_l,
    input  logic       reset_h,
    input  logic       start_h,
    input  logic       div_h,
`ifdef ALP_MDSQ_ABORT_EN
    input  logic       abort_h,
`endif
    output logic [9:0] opc_h,
    output logic [1:0] shf_l,
    output logic       cyin_l,
    output logic       a_si3_l,
    output logic       q_si0_l,
    input  logic       q_lsb_h,
    input  logic       n_h,
    input  logic       v_h,
    input  logic       z_h,
    output logic       busy_h,
    output logic       done_h,
    output logic       dz_h
);

    localparam int unsigned CntW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    typedef enum logic [2:0] {StIdle, StCheck, StStep, StFix, StDone} state_e;

    state_e            state_q, state_d;
    logic   [CntW-1:0] cnt_q, cnt_d;
    logic              div_q, div_d;
    logic              dz_q, dz_d;
    logic              qm1_q, qm1_d;
    logic              first_q, first_d;
    logic              psign_q, psign_d;
    logic              abort;

`ifdef ALP_MDSQ_ABORT_EN
    assign abort = abort_h;
`else
    assign abort = 1'b0;
`endif

    always_ff @(posedge qdck_l) begin
        if (reset_h) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            div_q   <= 1'b0;
            dz_q    <= 1'b0;
            qm1_q   <= 1'b0;
            first_q <= 1'b0;
            psign_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            div_q   <= div_d;
            dz_q    <= dz_d;
            qm1_q   <= qm1_d;
            first_q <= first_d;
            psign_q <= psign_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        div_d   = div_q;
        dz_d    = dz_q;
        qm1_d   = qm1_q;
        first_d = first_q;
        psign_d = psign_q;
        unique case (state_q)
            StIdle: begin
                if (start_h) begin
                    div_d   = div_h;
                    dz_d    = 1'b0;
                    cnt_d   = CntW'(WIDTH - 1);
                    qm1_d   = 1'b0;
                    first_d = 1'b1;
                    psign_d = 1'b0;
                    state_d = div_h ? StCheck : StStep;
                end
            end
            StCheck: begin
                // CHECK passes D through the ALU, so z_h flags a zero divisor
                if (z_h) begin
                    dz_d    = 1'b1;
                    state_d = StDone;
                end else begin
                    first_d = 1'b1;
                    state_d = StStep;
                end
            end
            StStep: begin
                if (div_q) begin
                    psign_d = n_h;
                    first_d = 1'b0;
                end else begin
                    qm1_d = q_lsb_h;
                end
                if (cnt_q == '0) begin
                    state_d = div_q ? StFix : StDone;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            StFix:   state_d = StDone;
            StDone:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
        if (abort && (state_q != StIdle)) begin
            state_d = StIdle;
            cnt_d   = '0;
            dz_d    = 1'b0;
            qm1_d   = 1'b0;
            first_d = 1'b0;
            psign_d = 1'b0;
        end
    end

    always_comb begin
        opc_h   = OPC_NOP;
        shf_l   = 2'b11;
        cyin_l  = 1'b1;
        a_si3_l = 1'b1;
        q_si0_l = 1'b1;
        busy_h  = (state_q != StIdle);
        done_h  = (state_q == StDone);
        dz_h    = dz_q;
        unique case (state_q)
            StCheck: opc_h = OPC_PASS;
            StStep: begin
                if (div_q) begin
                    if (first_q || !psign_q) begin
                        opc_h  = OPC_SUB;
                        cyin_l = 1'b0;
                    end else begin
                        opc_h = OPC_ADD;
                    end
                    shf_l   = 2'b01;
                    q_si0_l = n_h;
                end else begin
                    unique case ({q_lsb_h, qm1_q})
                        2'b10: begin
                            opc_h  = OPC_SUB;
                            cyin_l = 1'b0;
                        end
                        2'b01:   opc_h = OPC_ADD;
                        default: opc_h = OPC_PASS;
                    endcase
                    shf_l = 2'b10;
                    // Shift in the true sign, corrected for overflow
                    a_si3_l = ~(n_h ^ v_h);
                end
            end
            StFix:   opc_h = psign_q ? OPC_ADD : OPC_PASS;
            default: ;
        endcase
    end

endmodule

// File: tb/tb_alp_mdsq.sv
// Directed bench for alp_mdsq at WIDTH=4 with a small behavioural slice-chain model.
// Define ALP_MDSQ_ABORT_EN to also exercise the abort input.
module tb_alp_mdsq;

    localparam logic [9:0] NOP  = 10'h000;
    localparam logic [9:0] PASS = 10'h001;
    localparam logic [9:0] ADD  = 10'h002;
    localparam logic [9:0] SUB  = 10'h003;

    logic       qdck_l = 1'b0;
    logic       reset_h = 1'b1;
    logic       start_h = 1'b0;
    logic       div_h = 1'b0;
`ifdef ALP_MDSQ_ABORT_EN
    logic       abort_h = 1'b0;
`endif
    logic [9:0] opc_h;
    logic [1:0] shf_l;
    logic       cyin_l, a_si3_l, q_si0_l;
    logic       q_lsb_h, n_h, v_h, z_h;
    logic       busy_h, done_h, dz_h;

    int errors = 0;
    int checks = 0;

    always #5 qdck_l = ~qdck_l;

    alp_mdsq #(.WIDTH(4)) dut (
        .qdck_l  (qdck_l),
        .reset_h (reset_h),
        .start_h (start_h),
        .div_h   (div_h),
`ifdef ALP_MDSQ_ABORT_EN
        .abort_h (abort_h),
`endif
        .opc_h   (opc_h),
        .shf_l   (shf_l),
        .cyin_l  (cyin_l),
        .a_si3_l (a_si3_l),
        .q_si0_l (q_si0_l),
        .q_lsb_h (q_lsb_h),
        .n_h     (n_h),
        .v_h     (v_h),
        .z_h     (z_h),
        .busy_h  (busy_h),
        .done_h  (done_h),
        .dz_h    (dz_h)
    );

    // Slice-chain model: left shift feeds the ALU, right shift follows it.
    logic [3:0] ma, mq, md;
    logic [3:0] ld_a, ld_q, ld_d;
    logic       ld = 1'b0;
    logic [3:0] a_op, r;
    logic       shl, shr;

    always_comb begin
        shl  = (shf_l == 2'b01);
        shr  = (shf_l == 2'b10);
        a_op = shl ? {ma[2:0], mq[3]} : ma;
        r    = a_op;
        v_h  = 1'b0;
        if (opc_h == ADD) begin
            r   = a_op + md + {3'b000, ~cyin_l};
            v_h = (a_op[3] == md[3]) && (r[3] != a_op[3]);
        end else if (opc_h == SUB) begin
            r   = a_op + ~md + {3'b000, ~cyin_l};
            v_h = (a_op[3] != md[3]) && (r[3] != a_op[3]);
        end
        n_h     = r[3];
        z_h     = (md == 4'd0);
        q_lsb_h = mq[0];
    end

    always_ff @(posedge qdck_l) begin
        if (ld) begin
            ma <= ld_a;
            mq <= ld_q;
            md <= ld_d;
        end else if (opc_h != NOP) begin
            if (shr) begin
                ma <= {~a_si3_l, r[3:1]};
                mq <= {r[0], mq[3:1]};
            end else if (shl) begin
                ma <= r;
                mq <= {mq[2:0], ~q_si0_l};
            end else begin
                ma <= r;
            end
        end
    end

    task automatic load(input logic [3:0] a, input logic [3:0] q, input logic [3:0] d);
        @(negedge qdck_l);
        ld_a = a; ld_q = q; ld_d = d; ld = 1'b1;
        @(negedge qdck_l);
        ld = 1'b0;
    endtask

    // Returns at the negedge of cycle 1 (the cycle after start was sampled)
    task automatic pulse_start(input logic dv);
        @(negedge qdck_l);
        start_h = 1'b1; div_h = dv;
        @(negedge qdck_l);
        start_h = 1'b0;
    endtask

    task automatic test_reset;
        reset_h = 1'b1;
        repeat (3) @(negedge qdck_l);
        checks += 8;
        if (busy_h !== 1'b0) begin errors++; $display("FAIL rst_busy got=%b exp=0", busy_h); end
        if (done_h !== 1'b0) begin errors++; $display("FAIL rst_done got=%b exp=0", done_h); end
        if (dz_h !== 1'b0) begin errors++; $display("FAIL rst_dz got=%b exp=0", dz_h); end
        if (opc_h !== NOP) begin errors++; $display("FAIL rst_opc got=%h exp=%h", opc_h, NOP); end
        if (shf_l !== 2'b11) begin errors++; $display("FAIL rst_shf got=%b exp=11", shf_l); end
        if (cyin_l !== 1'b1) begin errors++; $display("FAIL rst_cyin got=%b exp=1", cyin_l); end
        if (a_si3_l !== 1'b1) begin errors++; $display("FAIL rst_asi got=%b exp=1", a_si3_l); end
        if (q_si0_l !== 1'b1) begin errors++; $display("FAIL rst_qsi got=%b exp=1", q_si0_l); end
        reset_h = 1'b0;
    endtask

    task automatic test_reset_mid;
        int nd;
        load(4'h0, 4'h6, 4'h3);
        pulse_start(1'b0);
        @(negedge qdck_l);
        reset_h = 1'b1;
        @(negedge qdck_l);
        reset_h = 1'b0;
        checks += 3;
        if (busy_h !== 1'b0) begin errors++; $display("FAIL midrst_busy got=%b exp=0", busy_h); end
        if (opc_h !== NOP) begin errors++; $display("FAIL midrst_opc got=%h exp=%h", opc_h, NOP); end
        if (shf_l !== 2'b11) begin errors++; $display("FAIL midrst_shf got=%b exp=11", shf_l); end
        nd = 0;
        for (int c = 0; c < 8; c++) begin
            if (done_h) nd++;
            @(negedge qdck_l);
        end
        checks++;
        if (nd !== 0) begin errors++; $display("FAIL midrst_nodone got=%0d exp=0", nd); end
    endtask

    task automatic test_multiply;
        logic [9:0] seq [1:4];
        logic [9:0] exp_seq [1:4];
        int dcyc;
        logic dzd;
        exp_seq[1] = PASS; exp_seq[2] = SUB; exp_seq[3] = PASS; exp_seq[4] = ADD;
        load(4'h0, 4'b0110, 4'h3);
        pulse_start(1'b0);
        dcyc = 0; dzd = 1'b1;
        for (int c = 1; c <= 10; c++) begin
            if (c <= 4) seq[c] = opc_h;
            if (done_h && dcyc == 0) begin dcyc = c; dzd = dz_h; end
            @(negedge qdck_l);
        end
        for (int i = 1; i <= 4; i++) begin
            checks++;
            if (seq[i] !== exp_seq[i]) begin
                errors++; $display("FAIL mul_opc%0d got=%h exp=%h", i, seq[i], exp_seq[i]);
            end
        end
        checks += 3;
        if (dcyc !== 5) begin errors++; $display("FAIL mul_done_cyc got=%0d exp=5", dcyc); end
        if ({ma, mq} !== 8'h12) begin errors++; $display("FAIL mul_result got=%h exp=12", {ma, mq}); end
        if (dzd !== 1'b0) begin errors++; $display("FAIL mul_dz got=%b exp=0", dzd); end
    endtask

    task automatic test_divide;
        logic [9:0] seq [1:6];
        logic [9:0] exp_seq [1:6];
        int dcyc;
        logic dzd;
        exp_seq[1] = PASS; exp_seq[2] = SUB; exp_seq[3] = ADD;
        exp_seq[4] = SUB;  exp_seq[5] = ADD; exp_seq[6] = ADD;
        load(4'h0, 4'hD, 4'h3);
        pulse_start(1'b1);
        dcyc = 0; dzd = 1'b1;
        for (int c = 1; c <= 12; c++) begin
            if (c <= 6) seq[c] = opc_h;
            if (done_h && dcyc == 0) begin dcyc = c; dzd = dz_h; end
            @(negedge qdck_l);
        end
        for (int i = 1; i <= 6; i++) begin
            checks++;
            if (seq[i] !== exp_seq[i]) begin
                errors++; $display("FAIL div_opc%0d got=%h exp=%h", i, seq[i], exp_seq[i]);
            end
        end
        checks += 4;
        if (dcyc !== 7) begin errors++; $display("FAIL div_done_cyc got=%0d exp=7", dcyc); end
        if (mq !== 4'd4) begin errors++; $display("FAIL div_quot got=%h exp=4", mq); end
        if (ma !== 4'd1) begin errors++; $display("FAIL div_rem got=%h exp=1", ma); end
        if (dzd !== 1'b0) begin errors++; $display("FAIL div_dz got=%b exp=0", dzd); end
    endtask

    task automatic test_div_zero;
        int dcyc;
        logic dzd;
        load(4'h0, 4'hD, 4'h0);
        pulse_start(1'b1);
        dcyc = 0; dzd = 1'b0;
        for (int c = 1; c <= 5; c++) begin
            if (done_h && dcyc == 0) begin dcyc = c; dzd = dz_h; end
            @(negedge qdck_l);
        end
        checks += 3;
        if (dcyc !== 2) begin errors++; $display("FAIL dz_done_cyc got=%0d exp=2", dcyc); end
        if (dzd !== 1'b1) begin errors++; $display("FAIL dz_at_done got=%b exp=1", dzd); end
        if (dz_h !== 1'b1) begin errors++; $display("FAIL dz_held got=%b exp=1", dz_h); end
        load(4'h0, 4'h1, 4'h1);
        pulse_start(1'b0);
        checks++;
        if (dz_h !== 1'b0) begin errors++; $display("FAIL dz_clear got=%b exp=0", dz_h); end
        repeat (8) @(negedge qdck_l);
    endtask

    task automatic test_back_to_back;
        int nd, dcyc;
        logic b6, b7;
        load(4'h0, 4'h5, 4'h2);
        @(negedge qdck_l);
        start_h = 1'b1; div_h = 1'b0;
        @(negedge qdck_l);
        nd = 0; dcyc = 0; b6 = 1'b1; b7 = 1'b0;
        for (int c = 1; c <= 7; c++) begin
            if (done_h) begin nd++; if (dcyc == 0) dcyc = c; end
            if (c == 6) b6 = busy_h;
            if (c == 7) b7 = busy_h;
            @(negedge qdck_l);
        end
        start_h = 1'b0;
        checks += 4;
        if (nd !== 1) begin errors++; $display("FAIL b2b_ndone got=%0d exp=1", nd); end
        if (dcyc !== 5) begin errors++; $display("FAIL b2b_done_cyc got=%0d exp=5", dcyc); end
        if (b6 !== 1'b0) begin errors++; $display("FAIL b2b_idle_gap got=%b exp=0", b6); end
        if (b7 !== 1'b1) begin errors++; $display("FAIL b2b_restart got=%b exp=1", b7); end
        nd = 0;
        for (int c = 0; c < 8; c++) begin
            if (done_h) nd++;
            @(negedge qdck_l);
        end
        checks++;
        if (nd !== 1) begin errors++; $display("FAIL b2b_second_done got=%0d exp=1", nd); end
    endtask

`ifdef ALP_MDSQ_ABORT_EN
    task automatic test_abort;
        int nd;
        load(4'h0, 4'hD, 4'h3);
        pulse_start(1'b1);
        @(negedge qdck_l);
        abort_h = 1'b1;
        @(negedge qdck_l);
        abort_h = 1'b0;
        checks += 4;
        if (busy_h !== 1'b0) begin errors++; $display("FAIL abort_busy got=%b exp=0", busy_h); end
        if (opc_h !== NOP) begin errors++; $display("FAIL abort_opc got=%h exp=%h", opc_h, NOP); end
        if (dz_h !== 1'b0) begin errors++; $display("FAIL abort_dz got=%b exp=0", dz_h); end
        nd = 0;
        for (int c = 0; c < 8; c++) begin
            if (done_h) nd++;
            @(negedge qdck_l);
        end
        if (nd !== 0) begin errors++; $display("FAIL abort_nodone got=%0d exp=0", nd); end
    endtask
`endif

    initial begin
        ld_a = '0; ld_q = '0; ld_d = '0;
        test_reset();
        test_reset_mid();
        test_multiply();
        test_divide();
        test_div_zero();
        test_back_to_back();
`ifdef ALP_MDSQ_ABORT_EN
        test_abort();
`endif
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
